// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, channel-width helper and beat type for the CIC comb section
package cic_pkg;

  localparam int MAX_STAGES   = 8;
  localparam int MAX_CHANNELS = 16;
  localparam int PKG_WIDTH    = 32;

  // Channel index width, floored at one bit so a single-channel build still has a tag.
  function automatic int ch_w_calc(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic                            valid;
    logic [$clog2(MAX_CHANNELS)-1:0] ch;
    logic [PKG_WIDTH-1:0]            data;
  } cic_beat_t;

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one comb stage y = x - x[n-M] with per-channel history
module cic_comb_stage #(
  parameter int WIDTH      = 32,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 2,
  parameter int CH_W       = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             advance_i,
  input  logic             in_valid_i,
  input  logic [CH_W-1:0]  in_ch_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [CH_W-1:0]  out_ch_o,
  output logic [WIDTH-1:0] out_data_o
);

  // Sized to the full tag range so any tag indexes safely; rows >= CHANNELS stay zero.
  localparam int HIST_N = 1 << CH_W;

  logic [WIDTH-1:0] hist [HIST_N][DIFF_DELAY];
  logic             ch_ok;
  logic [WIDTH-1:0] tap;

  assign ch_ok = (32'(in_ch_i) < CHANNELS);

  always_comb begin
    tap = '0;
    if (ch_ok) tap = hist[in_ch_i][DIFF_DELAY-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      out_data_o  <= '0;
      for (int c = 0; c < HIST_N; c++)
        for (int d = 0; d < DIFF_DELAY; d++)
          hist[c][d] <= '0;
    end else if (clr_i) begin
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      out_data_o  <= '0;
      for (int c = 0; c < HIST_N; c++)
        for (int d = 0; d < DIFF_DELAY; d++)
          hist[c][d] <= '0;
    end else if (advance_i) begin
      out_valid_o <= in_valid_i;
      // Bubbles leave data, tag and history untouched.
      if (in_valid_i) begin
        out_ch_o   <= in_ch_i;
        out_data_o <= in_data_i - tap;
        if (ch_ok) begin
          for (int d = DIFF_DELAY - 1; d > 0; d--)
            hist[in_ch_i][d] <= hist[in_ch_i][d-1];
          hist[in_ch_i][0] <= in_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/cic_comb_mc.sv
// rtl/cic_comb_mc.sv - multi-stage multi-channel CIC comb chain with valid/ready handshake
module cic_comb_mc
  import cic_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 5,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 2,
  parameter int CH_W       = ch_w_calc(CHANNELS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [CH_W-1:0]  in_ch_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CH_W-1:0]  out_ch_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic             vld [STAGES+1];
  logic [CH_W-1:0]  chs [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];
  logic             advance;

  // Whole chain moves together; any output stall freezes every stage.
  assign advance    = ~vld[STAGES] | out_ready_i;
  assign in_ready_o = advance;

  assign vld[0] = in_valid_i;
  assign chs[0] = in_ch_i;
  assign dat[0] = in_data_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cic_comb_stage #(
      .WIDTH      (WIDTH),
      .DIFF_DELAY (DIFF_DELAY),
      .CHANNELS   (CHANNELS),
      .CH_W       (CH_W)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (clr_i),
      .advance_i   (advance),
      .in_valid_i  (vld[k]),
      .in_ch_i     (chs[k]),
      .in_data_i   (dat[k]),
      .out_valid_o (vld[k+1]),
      .out_ch_o    (chs[k+1]),
      .out_data_o  (dat[k+1])
    );
  end

  assign out_valid_o = vld[STAGES];
  assign out_ch_o    = chs[STAGES];
  assign out_data_o  = dat[STAGES];

endmodule

// File: tb/tb_cic_comb_mc.sv
// tb/tb_cic_comb_mc.sv - self-checking bench for cic_comb_mc over four configurations
module tb_cic_comb_mc;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [15:0] in_data;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic [15:0] od0, od1, od2, od3;
  logic [0:0]  oc0, oc1, oc2;
  logic [1:0]  oc3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_rdy = 0;
  int lat [4]  = '{1, 2, 1, 3};

  logic [15:0] got_d [4][$];
  logic [1:0]  got_c [4][$];
  int          got_t [4][$];
  logic [15:0] exp_d [$];
  logic [1:0]  exp_c [$];
  logic [15:0] mpast [9][$];

  typedef struct {
    int          dut;
    int          n;
    logic [15:0] din  [4];
    logic [1:0]  cin  [4];
    logic [15:0] dout [4];
    logic [1:0]  cout [4];
  } vec_t;
  vec_t tbl [5];

  // dut0: S1 M1 CH2, dut1: S2 M1 CH1, dut2: S1 M2 CH1, dut3: S3 M2 CH3
  cic_comb_mc #(.WIDTH(16), .STAGES(1), .DIFF_DELAY(1), .CHANNELS(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_ch_i(in_ch[0:0]), .in_data_i(in_data), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_ch_o(oc0), .out_data_o(od0));
  cic_comb_mc #(.WIDTH(16), .STAGES(2), .DIFF_DELAY(1), .CHANNELS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_ch_i(1'b0), .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_ch_o(oc1), .out_data_o(od1));
  cic_comb_mc #(.WIDTH(16), .STAGES(1), .DIFF_DELAY(2), .CHANNELS(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy2),
    .in_ch_i(1'b0), .in_data_i(in_data), .out_valid_o(ov2), .out_ready_i(out_ready),
    .out_ch_o(oc2), .out_data_o(od2));
  cic_comb_mc #(.WIDTH(16), .STAGES(3), .DIFF_DELAY(2), .CHANNELS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(rdy3),
    .in_ch_i(in_ch), .in_data_i(in_data), .out_valid_o(ov3), .out_ready_i(out_ready),
    .out_ch_o(oc3), .out_data_o(od3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output handshakes are observed mid-cycle; clr and rst discard whatever is presented.
  always @(negedge clk) begin
    if (!rst && !clr && out_ready) begin
      if (ov0) begin got_d[0].push_back(od0); got_c[0].push_back({1'b0, oc0}); got_t[0].push_back(cyc); end
      if (ov1) begin got_d[1].push_back(od1); got_c[1].push_back({1'b0, oc1}); got_t[1].push_back(cyc); end
      if (ov2) begin got_d[2].push_back(od2); got_c[2].push_back({1'b0, oc2}); got_t[2].push_back(cyc); end
      if (ov3) begin got_d[3].push_back(od3); got_c[3].push_back(oc3);         got_t[3].push_back(cyc); end
    end
  end

  // Reference for dut3: three cascaded y[n] = x[n] - x[n-2] per channel, history kept as sample lists.
  function automatic void model_clear();
    for (int i = 0; i < 9; i++) mpast[i].delete();
    exp_d.delete();
    exp_c.delete();
  endfunction

  function automatic void model_push(input logic [15:0] d, input logic [1:0] c);
    logic [15:0] x;
    logic [15:0] tap;
    int          idx;
    x = d;
    if (c < 2'd3) begin
      for (int k = 0; k < 3; k++) begin
        idx = k * 3 + int'(c);
        tap = (mpast[idx].size() >= 2) ? mpast[idx][mpast[idx].size() - 2] : 16'h0;
        mpast[idx].push_back(x);
        x = x - tap;
      end
    end
    exp_d.push_back(x);
    exp_c.push_back(c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic flush();
    clr = 1'b1;
    in_valid = 1'b0;
    tick();
    clr = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] c, output int t);
    bit ok;
    ok = 1'b0;
    t = -1;
    in_valid = 1'b1;
    in_data = d;
    in_ch = c;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rdy3 && !clr && !rst) begin
        ok = 1'b1;
        t = cyc;
        model_push(d, c);
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: sample %0h not accepted", d);
    end
  endtask

  task automatic cmp_stream(input string tag, input int base);
    int n;
    n = got_d[3].size() - base;
    chk({tag, "_count"}, 32'(n), 32'(exp_d.size()));
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got_d[3][base + i]), 32'(exp_d[i]));
      chk($sformatf("%s_ch%0d", tag, i), 32'(got_c[3][base + i]), 32'(exp_c[i]));
    end
  endtask

  initial begin
    int t;
    int acc [4];
    int base;
    int dn;
    int gn;
    logic [15:0] hold_d;
    logic [1:0]  hold_c;

    tbl[0].dut = 0; tbl[0].n = 3;
    tbl[0].din  = '{16'd5, 16'd8, 16'd3, 16'd0};  tbl[0].cin  = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[0].dout = '{16'd5, 16'd3, 16'hFFFB, 16'd0}; tbl[0].cout = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[1].dut = 0; tbl[1].n = 2;
    tbl[1].din  = '{16'hFFFF, 16'h0000, 16'd0, 16'd0}; tbl[1].cin  = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[1].dout = '{16'hFFFF, 16'h0001, 16'd0, 16'd0}; tbl[1].cout = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[2].dut = 0; tbl[2].n = 4;
    tbl[2].din  = '{16'd10, 16'd100, 16'd15, 16'd90};  tbl[2].cin  = '{2'd0, 2'd1, 2'd0, 2'd1};
    tbl[2].dout = '{16'd10, 16'd100, 16'd5, 16'hFFF6}; tbl[2].cout = '{2'd0, 2'd1, 2'd0, 2'd1};
    tbl[3].dut = 1; tbl[3].n = 4;
    tbl[3].din  = '{16'd1, 16'd0, 16'd0, 16'd0};      tbl[3].cin  = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[3].dout = '{16'd1, 16'hFFFE, 16'd1, 16'd0};   tbl[3].cout = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[4].dut = 2; tbl[4].n = 3;
    tbl[4].din  = '{16'd1, 16'd0, 16'd0, 16'd0};      tbl[4].cin  = '{2'd0, 2'd0, 2'd0, 2'd0};
    tbl[4].dout = '{16'd1, 16'd0, 16'hFFFF, 16'd0};   tbl[4].cout = '{2'd0, 2'd0, 2'd0, 2'd0};

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_ch = 2'd0; in_data = 16'd0; out_ready = 1'b1;
    idle(3);
    chk("rst_ov", 32'({ov0, ov1, ov2, ov3}), 32'h0);
    chk("rst_od3", 32'(od3), 32'h0);
    chk("rst_oc3", 32'(oc3), 32'h0);
    chk("rst_rdy", 32'({rdy0, rdy1, rdy2, rdy3}), 32'hF);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      flush();
      dn = tbl[v].dut;
      base = got_d[dn].size();
      for (int i = 0; i < tbl[v].n; i++) begin
        send(tbl[v].din[i], tbl[v].cin[i], t);
        acc[i] = t;
      end
      idle(8);
      gn = got_d[dn].size() - base;
      chk($sformatf("v%0d_count", v), 32'(gn), 32'(tbl[v].n));
      for (int i = 0; i < tbl[v].n && i < gn; i++) begin
        chk($sformatf("v%0d_data%0d", v, i), 32'(got_d[dn][base + i]), 32'(tbl[v].dout[i]));
        chk($sformatf("v%0d_ch%0d", v, i), 32'(got_c[dn][base + i]), 32'(tbl[v].cout[i]));
        chk($sformatf("v%0d_lat%0d", v, i), 32'(got_t[dn][base + i] - acc[i]), 32'(lat[dn]));
      end
    end

    // Backpressure: three stalled cycles with a pending input that must not be taken.
    flush();
    base = got_d[3].size();
    send(16'd100, 2'd0, t);
    send(16'd20, 2'd1, t);
    send(16'd33, 2'd0, t);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'd55; in_ch = 2'd1;
    hold_d = od3;
    hold_c = oc3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_ov%0d", i), 32'(ov3), 32'h1);
      chk($sformatf("stall_rdy%0d", i), 32'(rdy3), 32'h0);
      chk($sformatf("stall_od%0d", i), 32'(od3), 32'(hold_d));
      chk($sformatf("stall_oc%0d", i), 32'(oc3), 32'(hold_c));
      tick();
    end
    out_ready = 1'b1;
    send(16'd55, 2'd1, t);
    send(16'd200, 2'd3, t);
    idle(10);
    cmp_stream("bp", base);

    // Clear with a same-cycle input and two samples in flight.
    flush();
    send(16'd50, 2'd0, t);
    send(16'd60, 2'd1, t);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'd99; in_ch = 2'd0;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("clr_ov_next", 32'(ov3), 32'h0);
    base = got_d[3].size();
    idle(6);
    chk("clr_no_leak", 32'(got_d[3].size() - base), 32'h0);
    send(16'd7, 2'd0, t);
    idle(6);
    chk("clr_after_count", 32'(got_d[3].size() - base), 32'h1);
    if (got_d[3].size() > base) begin
      chk("clr_after_data", 32'(got_d[3][base]), 32'h7);
      chk("clr_after_lat", 32'(got_t[3][base] - t), 32'h3);
    end

    // Asynchronous reset while the output is stalled.
    flush();
    out_ready = 1'b0;
    send(16'd11, 2'd2, t);
    idle(4);
    chk("pre_rst_ov", 32'(ov3), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", 32'(ov3), 32'h0);
    chk("arst_od", 32'(od3), 32'h0);
    chk("arst_oc", 32'(oc3), 32'h0);
    tick();
    rst = 1'b0;
    model_clear();
    out_ready = 1'b1;
    base = got_d[3].size();
    send(16'd4, 2'd2, t);
    idle(6);
    chk("post_rst_count", 32'(got_d[3].size() - base), 32'h1);
    if (got_d[3].size() > base) chk("post_rst_data", 32'(got_d[3][base]), 32'h4);

    // Randomized traffic, random backpressure, all channels including the out-of-range tag.
    flush();
    base = got_d[3].size();
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send(16'($urandom), 2'($urandom_range(0, 3)), t);
    end
    rand_rdy = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(20);
    cmp_stream("rnd", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/cic_comb_mc.md
Name: cic_comb_mc

Overview:
- Parametrised multi-stage, multi-channel comb section for the I2S/PDM CIC decimator.
- Sits after the integrator/decimation point and before the uDMA RX packer.
- Runs STAGES cascaded comb stages with programmable differential delay over time-multiplexed channels.
- Each stage keeps independent per-channel history.
- Uses a valid/ready stream on both sides, with full-pipeline stall on output backpressure.

Parameters:
- WIDTH, 32: data width of every stage; two's-complement, modulo 2^WIDTH.
- STAGES, 5: number of cascaded comb stages (1..8).
- DIFF_DELAY, 1: differential delay M per stage (1 or 2).
- CHANNELS, 2: number of time-multiplexed channels (1..16).
- CH_W, $clog2(CHANNELS) floored at 1: channel index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous clear of all history and the pipeline.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  block can accept a sample.
- in_ch_i  in  CH_W  channel index of input sample.
- in_data_i  in  WIDTH  input sample.
- out_valid_o  out  1  output sample valid.
- out_ready_i  in  1  downstream accepts.
- out_ch_o  out  CH_W  channel index of output.
- out_data_o  out  WIDTH  comb output.

Behaviour:
- Reset (rst_i high, async): all history, pipeline data, valids and channel tags clear to 0; out_valid_o=0, out_data_o=0, out_ch_o=0.
- advance = ~out_valid_o | out_ready_i; in_ready_o = advance (combinational).
- Input is accepted when in_valid_i & in_ready_o.
- Pipeline: one register per stage. Stage k computes y = x - hist[k][ch][DIFF_DELAY-1], then shifts hist[k][ch] (hist[0] <= x).
  - This happens only when that stage's input is valid and advance=1.
- Stage 0's input is the accepted sample; stage k's input is the stage k-1 register.
- Latency: exactly STAGES cycles from acceptance to out_valid_o when not stalled. Throughput is 1 sample/cycle.
- Stall (advance=0): every stage register, valid bit and history entry holds; out_data_o and out_ch_o stay stable while out_valid_o=1.
- Channel tag travels with the data. History for channel c is touched only by samples tagged c.
- Channels may arrive in any order and may repeat.
- Arithmetic: plain WIDTH-bit subtraction with wrap-around, no saturation and no overflow flag. CIC gain correctness relies on the wrap.
- in_ch_i >= CHANNELS: the sample is accepted and passed through with its tag, but it neither reads nor updates any history (treated as history 0). A bench checker flags this case.
- clr_i (sync):
  - Zeroes all history, all stage valids and out_valid_o; data registers go to 0.
  - Has priority over a same-cycle input; that input is dropped even if in_valid_i & in_ready_o.
  - Has priority over a same-cycle output handshake; the output is considered consumed.
- Reset or clr mid-stream: in-flight samples are discarded and no partial output appears. The next accepted sample sees zero history.
- A valid bubble (no input) propagates as invalid. Bubbles do not modify history.

Decomposition:
- Package cic_pkg holds:
  - the CH_W computation function;
  - localparams MAX_STAGES=8 and MAX_CHANNELS=16;
  - typedef cic_beat_t {valid, ch, data}, parametrised through the package width constant or redeclared locally.
- Sub-module cic_comb_stage (one stage holding its CHANNELS x DIFF_DELAY history array, with advance, clr and channel tag in and out), instantiated STAGES times in a generate loop.
- The top holds only the handshake logic and the stage chain.

Test Plan:
- WIDTH=16, STAGES=1, M=1, CH=1, out_ready=1: inputs 5,8,3 -> outputs 5,3,0xFFFB, each 1 cycle after acceptance.
- STAGES=2, M=1: impulse 1,0,0,0 -> 1,0xFFFE(-2),1,0 after 2 cycles. STAGES=1, M=2: impulse 1,0,0 -> 1,0,0xFFFF.
- Wrap: STAGES=1, M=1, inputs 0xFFFF then 0x0000 -> 0xFFFF then 0x0001.
- CH=2 interleave: ch0:10, ch1:100, ch0:15, ch1:90 -> ch0:10, ch1:100, ch0:5, ch1:0xFFF6; out_ch_o matches each.
- Backpressure: out_ready low for 3 cycles mid-stream -> in_ready low, out_data/out_ch stable. Sequence resumes with no loss or duplication; output equals the golden model.
- clr_i with in_valid=1 while 2 samples are in flight -> out_valid=0 next cycle and the in-flight samples never appear. Next input 7 -> output 7.
- rst_i asserted asynchronously mid-stall -> all outputs 0 immediately. After release, the first sample 4 -> output 4.
